// File: rtl/inidata_stencil_buf.sv
// Per-point initial-data buffer: loads packed records, then sweeps every point emitting
// centre scalars and (2R+1)-wide stencil windows for alpha, phi and psi under valid/ready.
module inidata_stencil_buf #(
  parameter int DW       = 64,
  parameter int IN_W     = 512,
  parameter int DEPTH    = 256,
  parameter int AW       = 8,
  parameter int R        = 2,
  parameter int BND_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         in_data,
  input  logic                    in_last,
  input  logic                    start,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [AW-1:0]           out_idx,
  output logic [DW-1:0]           r_i,
  output logic [DW-1:0]           K_i,
  output logic [DW-1:0]           pi_m_i,
  output logic [(2*R+1)*DW-1:0]   alpha_win,
  output logic [(2*R+1)*DW-1:0]   phi_win,
  output logic [(2*R+1)*DW-1:0]   psi_win,
  output logic                    out_last,
  output logic [AW:0]             n_points,
  output logic                    busy,
  output logic                    done
);

  localparam int W = 2*R+1;
  localparam logic signed [AW+1:0] R_S = (AW+2)'(R);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SWEEP = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state_r, state_s;

  logic [DW-1:0] r_mem     [DEPTH];
  logic [DW-1:0] alpha_mem [DEPTH];
  logic [DW-1:0] k_mem     [DEPTH];
  logic [DW-1:0] phi_mem   [DEPTH];
  logic [DW-1:0] pi_mem    [DEPTH];
  logic [DW-1:0] psi_mem   [DEPTH];

  logic [AW:0]   wr_ptr_r;
  logic [AW-1:0] rd_r;
  logic          in_ready_s;
  logic          accept_s;
  logic          start_go_s;
  logic          load_out_s;
  logic          drain_fire_s;
  logic          done_s;
  logic          is_last_s;
  logic [W*DW-1:0] alpha_win_s, phi_win_s, psi_win_s;

  // Resolves a neighbour index j; bit AW set means the slot reads as zero.
  function automatic logic [AW:0] resolve(input logic signed [AW+1:0] j, input logic [AW:0] n);
    logic signed [AW+1:0] n_sv;
    logic signed [AW+1:0] t_sv;
    logic [AW:0]          res;
    n_sv = $signed({1'b0, n});
    t_sv = j;
    res  = {1'b0, j[AW-1:0]};
    if (j[AW+1]) begin
      if (BND_MODE == 0) begin
        res = {1'b1, {AW{1'b0}}};
      end else if (BND_MODE == 2 && R_S < n_sv) begin
        t_sv = j + n_sv;
        res  = {1'b0, t_sv[AW-1:0]};
      end else begin
        res = {1'b0, {AW{1'b0}}};
      end
    end else if (j >= n_sv) begin
      if (BND_MODE == 0) begin
        res = {1'b1, {AW{1'b0}}};
      end else if (BND_MODE == 2 && R_S < n_sv) begin
        t_sv = j - n_sv;
        res  = {1'b0, t_sv[AW-1:0]};
      end else begin
        t_sv = n_sv - (AW+2)'(1);
        res  = {1'b0, t_sv[AW-1:0]};
      end
    end else begin
      res = {1'b0, j[AW-1:0]};
    end
    return res;
  endfunction

  assign in_ready  = in_ready_s;
  assign busy      = (state_r != IDLE);
  assign is_last_s = ({1'b0, rd_r} == (n_points - (AW+1)'(1)));

  // Next-state and handshake strobes.
  always_comb begin
    state_s      = state_r;
    in_ready_s   = 1'b0;
    accept_s     = 1'b0;
    start_go_s   = 1'b0;
    load_out_s   = 1'b0;
    drain_fire_s = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = !start;
        if (start) begin
          if (n_points == '0) begin
            done_s = 1'b1;
          end else begin
            start_go_s = 1'b1;
            state_s    = SWEEP;
          end
        end else if (in_valid) begin
          accept_s = 1'b1;
          state_s  = in_last ? IDLE : LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        in_ready_s = (wr_ptr_r < (AW+1)'(DEPTH));
        if (in_valid && in_ready_s) begin
          accept_s = 1'b1;
          state_s  = in_last ? IDLE : LOAD;
        end else begin
          state_s = LOAD;
        end
      end
      SWEEP: begin
        if (!out_valid || out_ready) begin
          load_out_s = 1'b1;
          state_s    = is_last_s ? DRAIN : SWEEP;
        end else begin
          state_s = SWEEP;
        end
      end
      DRAIN: begin
        if (out_valid && out_ready) begin
          drain_fire_s = 1'b1;
          done_s       = 1'b1;
          state_s      = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Stencil window gather around rd with boundary resolution.
  always_comb begin
    logic signed [AW+1:0] j_s;
    logic [AW:0]          ra_s;
    alpha_win_s = '0;
    phi_win_s   = '0;
    psi_win_s   = '0;
    j_s         = '0;
    ra_s        = '0;
    for (int k = 0; k < W; k++) begin
      j_s  = $signed({2'b00, rd_r}) - R_S + $signed((AW+2)'(k));
      ra_s = resolve(j_s, n_points);
      if (ra_s[AW]) begin
        alpha_win_s[k*DW +: DW] = '0;
        phi_win_s[k*DW +: DW]   = '0;
        psi_win_s[k*DW +: DW]   = '0;
      end else begin
        alpha_win_s[k*DW +: DW] = alpha_mem[ra_s[AW-1:0]];
        phi_win_s[k*DW +: DW]   = phi_mem[ra_s[AW-1:0]];
        psi_win_s[k*DW +: DW]   = psi_mem[ra_s[AW-1:0]];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Record storage; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (accept_s && !rst) begin
      r_mem[wr_ptr_r[AW-1:0]]     <= in_data[IN_W-1-0*DW -: DW];
      alpha_mem[wr_ptr_r[AW-1:0]] <= in_data[IN_W-1-1*DW -: DW];
      k_mem[wr_ptr_r[AW-1:0]]     <= in_data[IN_W-1-2*DW -: DW];
      phi_mem[wr_ptr_r[AW-1:0]]   <= in_data[IN_W-1-3*DW -: DW];
      pi_mem[wr_ptr_r[AW-1:0]]    <= in_data[IN_W-1-4*DW -: DW];
      psi_mem[wr_ptr_r[AW-1:0]]   <= in_data[IN_W-1-5*DW -: DW];
    end
  end

  // Load pointers, sweep pointer and the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r  <= '0;
      n_points  <= '0;
      rd_r      <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      r_i       <= '0;
      K_i       <= '0;
      pi_m_i    <= '0;
      alpha_win <= '0;
      phi_win   <= '0;
      psi_win   <= '0;
    end else begin
      done <= done_s;
      // wr_ptr is always 0 in IDLE, so the same update covers the first record.
      if (accept_s) begin
        if (in_last) begin
          n_points <= wr_ptr_r + (AW+1)'(1);
          wr_ptr_r <= '0;
        end else begin
          wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
        end
      end
      if (start_go_s) begin
        rd_r <= '0;
      end
      if (load_out_s) begin
        out_valid <= 1'b1;
        out_idx   <= rd_r;
        out_last  <= is_last_s;
        r_i       <= r_mem[rd_r];
        K_i       <= k_mem[rd_r];
        pi_m_i    <= pi_mem[rd_r];
        alpha_win <= alpha_win_s;
        phi_win   <= phi_win_s;
        psi_win   <= psi_win_s;
        rd_r      <= rd_r + AW'(1);
      end else if (drain_fire_s) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inidata_stencil_buf.sv
// Scoreboard bench: three instances (zero-pad, clamp, periodic) share one stimulus stream
// and are checked against a reference window model.
module tb_inidata_stencil_buf;
  localparam int DW = 64, IN_W = 512, DEPTH = 256, AW = 8, R = 2;
  localparam int W  = 2*R+1;
  localparam int CW = W*DW;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic          last;
    logic [DW-1:0] r;
    logic [DW-1:0] k;
    logic [DW-1:0] pi;
    logic [CW-1:0] aw;
    logic [CW-1:0] pw;
    logic [CW-1:0] sw;
  } exp_t;

  logic clk = 1'b0;
  logic rst, in_valid, in_last, start, out_ready;
  logic [IN_W-1:0] in_data;

  logic          irdy [3], ov [3], olast [3], busy_o [3], done_o [3];
  logic [AW-1:0] oidx [3];
  logic [DW-1:0] ri [3], ki [3], pii [3];
  logic [CW-1:0] aw [3], pw [3], sw [3];
  logic [AW:0]   np [3];

  exp_t          sbq [3][$];
  logic [DW-1:0] ref_f [6][DEPTH];
  int            n_model;
  int            n_tests, n_fail;
  int            done_cnt [3], out_cnt [3];
  bit            rand_rdy;
  logic [CW-1:0] exp_c [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inidata_stencil_buf #(.DW(DW), .IN_W(IN_W), .DEPTH(DEPTH), .AW(AW), .R(R), .BND_MODE(g)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[g]), .in_data(in_data),
      .in_last(in_last), .start(start), .out_valid(ov[g]), .out_ready(out_ready),
      .out_idx(oidx[g]), .r_i(ri[g]), .K_i(ki[g]), .pi_m_i(pii[g]),
      .alpha_win(aw[g]), .phi_win(pw[g]), .psi_win(sw[g]), .out_last(olast[g]),
      .n_points(np[g]), .busy(busy_o[g]), .done(done_o[g]));
  end

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [DW-1:0] win_val(input int mode, input int fld, input int j);
    if (j >= 0 && j < n_model) return ref_f[fld][j];
    if (mode == 0) return '0;
    if (mode == 2 && R < n_model) return ref_f[fld][((j % n_model) + n_model) % n_model];
    return ref_f[fld][(j < 0) ? 0 : n_model - 1];
  endfunction

  task automatic push_expected();
    exp_t e;
    for (int m = 0; m < 3; m++) begin
      for (int i = 0; i < n_model; i++) begin
        e      = '0;
        e.idx  = AW'(i);
        e.last = (i == n_model - 1);
        e.r    = ref_f[0][i];
        e.k    = ref_f[2][i];
        e.pi   = ref_f[4][i];
        for (int k = 0; k < W; k++) begin
          e.aw[k*DW +: DW] = win_val(m, 1, i - R + k);
          e.pw[k*DW +: DW] = win_val(m, 3, i - R + k);
          e.sw[k*DW +: DW] = win_val(m, 5, i - R + k);
        end
        sbq[m].push_back(e);
      end
    end
  endtask

  // Output monitor: head of queue must match while valid; pop on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int m = 0; m < 3; m++) begin
        if (done_o[m] === 1'b1) done_cnt[m]++;
        if (ov[m] === 1'b1) begin
          if (sbq[m].size() == 0) begin
            check($sformatf("unexpected_out_m%0d", m), CW'(1), CW'(0));
          end else begin
            e = sbq[m][0];
            check($sformatf("idx_m%0d", m),  CW'(oidx[m]),  CW'(e.idx));
            check($sformatf("last_m%0d", m), CW'(olast[m]), CW'(e.last));
            check($sformatf("r_m%0d", m),    CW'(ri[m]),    CW'(e.r));
            check($sformatf("K_m%0d", m),    CW'(ki[m]),    CW'(e.k));
            check($sformatf("pi_m%0d", m),   CW'(pii[m]),   CW'(e.pi));
            check($sformatf("awin_m%0d", m), aw[m], e.aw);
            check($sformatf("pwin_m%0d", m), pw[m], e.pw);
            check($sformatf("swin_m%0d", m), sw[m], e.sw);
            if (out_ready) begin
              void'(sbq[m].pop_front());
              out_cnt[m]++;
            end
          end
        end
      end
    end
  end

  // Random backpressure during selected sweeps.
  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic do_reset();
    rst = 1'b1;
    for (int m = 0; m < 3; m++) sbq[m].delete();
    @(posedge clk); #1;
    rst = 1'b0;
    n_model = 0;
  endtask

  task automatic load(input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      in_data = '0;
      in_data[IN_W-1-0*DW -: DW] = DW'(i);
      in_data[IN_W-1-1*DW -: DW] = DW'(100 + i);
      in_data[IN_W-1-2*DW -: DW] = DW'(400 + i);
      in_data[IN_W-1-3*DW -: DW] = DW'(200 + i);
      in_data[IN_W-1-4*DW -: DW] = DW'(500 + i);
      in_data[IN_W-1-5*DW -: DW] = DW'(300 + i);
      ref_f[0][i] = DW'(i);       ref_f[1][i] = DW'(100 + i);
      ref_f[2][i] = DW'(400 + i); ref_f[3][i] = DW'(200 + i);
      ref_f[4][i] = DW'(500 + i); ref_f[5][i] = DW'(300 + i);
      in_valid = 1'b1;
      in_last  = with_last && (i == n - 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (with_last) n_model = n;
  endtask

  task automatic do_sweep(input bit rnd, input bit consts);
    int base_d [3];
    int base_o [3];
    for (int m = 0; m < 3; m++) begin
      base_d[m] = done_cnt[m];
      base_o[m] = out_cnt[m];
    end
    push_expected();
    out_ready = 1'b1;
    rand_rdy  = rnd;
    start     = 1'b1;
    in_valid  = consts;
    #1;
    for (int m = 0; m < 3; m++) check($sformatf("start_wins_m%0d", m), CW'(irdy[m]), CW'(0));
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    check("lat1_valid", CW'(ov[0]), CW'(0));
    check("busy_sweep", CW'(busy_o[0]), CW'(1));
    @(posedge clk); #1;
    check("lat2_valid", CW'(ov[0]), CW'(1));
    if (consts) begin
      for (int m = 0; m < 3; m++) check($sformatf("idx0_awin_m%0d", m), aw[m], exp_c[m]);
    end
    for (int c = 0; c < 400 && done_cnt[0] == base_d[0]; c++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    for (int m = 0; m < 3; m++) begin
      check($sformatf("done_once_m%0d", m), CW'(done_cnt[m] - base_d[m]), CW'(1));
      check($sformatf("out_count_m%0d", m), CW'(out_cnt[m] - base_o[m]), CW'(n_model));
      check($sformatf("sb_empty_m%0d", m), CW'(sbq[m].size()), CW'(0));
      check($sformatf("npoints_keep_m%0d", m), CW'(np[m]), CW'(n_model));
    end
  endtask

  task automatic zero_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("zero_done_pulse", CW'(done_o[0]), CW'(1));
    check("zero_idle", CW'(busy_o[0]), CW'(0));
    @(posedge clk); #1;
    check("zero_done_low", CW'(done_o[0]), CW'(0));
    repeat (5) begin
      @(posedge clk); #1;
      check("zero_no_valid", CW'(ov[0]), CW'(0));
    end
  endtask

  initial begin
    bit found;
    n_tests = 0; n_fail = 0; n_model = 0;
    rand_rdy = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0; out_ready = 1'b1; in_data = '0;
    for (int m = 0; m < 3; m++) begin done_cnt[m] = 0; out_cnt[m] = 0; end
    exp_c[0] = {64'd102, 64'd101, 64'd100, 64'd0,   64'd0};
    exp_c[1] = {64'd102, 64'd101, 64'd100, 64'd100, 64'd100};
    exp_c[2] = {64'd102, 64'd101, 64'd100, 64'd107, 64'd106};
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    check("rst_in_ready", CW'(irdy[0]), CW'(1));
    check("rst_out_valid", CW'(ov[0]), CW'(0));
    check("rst_busy", CW'(busy_o[0]), CW'(0));
    check("rst_done", CW'(done_o[0]), CW'(0));
    check("rst_npoints", CW'(np[0]), CW'(0));
    check("rst_out_idx", CW'(oidx[0]), CW'(0));
    check("rst_out_last", CW'(olast[0]), CW'(0));
    check("rst_alpha_win", aw[0], CW'(0));
    check("rst_r_i", CW'(ri[0]), CW'(0));

    load(8, 1'b1);
    check("npoints_8", CW'(np[0]), CW'(8));
    do_sweep(1'b0, 1'b1);
    do_sweep(1'b1, 1'b0);

    // Fill to DEPTH without in_last; the block must then refuse further records.
    load(DEPTH, 1'b0);
    n_model = 8;
    check("full_in_ready", CW'(irdy[0]), CW'(0));
    check("full_busy", CW'(busy_o[0]), CW'(1));
    in_valid = 1'b1; in_last = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    check("full_last_rejected", CW'(np[0]), CW'(8));
    check("full_still_load", CW'(busy_o[0]), CW'(1));
    do_reset();
    check("full_rst_npoints", CW'(np[0]), CW'(0));
    check("full_rst_in_ready", CW'(irdy[0]), CW'(1));
    check("full_rst_busy", CW'(busy_o[0]), CW'(0));

    zero_start();

    // Reset while the third point is on the output.
    load(8, 1'b1);
    push_expected();
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      found = (ov[0] === 1'b1) && (oidx[0] == AW'(2));
    end
    check("third_out_seen", CW'(found), CW'(1));
    #1;
    rst = 1'b1;
    for (int m = 0; m < 3; m++) sbq[m].delete();
    @(posedge clk); #1;
    rst = 1'b0;
    n_model = 0;
    check("midrst_valid", CW'(ov[0]), CW'(0));
    check("midrst_busy", CW'(busy_o[0]), CW'(0));
    check("midrst_npoints", CW'(np[0]), CW'(0));
    zero_start();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
